// File: rtl/vend_controller.sv
// Vending transaction controller: selection, stock check, payment handshake
// with timeout, timed dispense, and per-item stock bookkeeping with restock.
module vend_controller #(
  parameter int unsigned NUM_ITEMS       = 4,
  parameter int unsigned STOCK_W         = 4,
  parameter int unsigned INIT_STOCK      = 5,
  parameter int unsigned PAY_TIMEOUT     = 16,
  parameter int unsigned DISPENSE_CYCLES = 3,
  localparam int unsigned IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_valid,
  input  logic [IDX_W-1:0]   sel_item,
  input  logic               restock_valid,
  input  logic [IDX_W-1:0]   restock_item,
  output logic               pay_req,
  input  logic               pay_done,
  output logic               dispense,
  output logic [IDX_W-1:0]   dispense_item,
  output logic               busy,
  output logic               sold_out,
  output logic               timeout_err,
  output logic               stray_done,
  output logic [STOCK_W-1:0] stock_level
);

  localparam int unsigned WAIT_W = $clog2(PAY_TIMEOUT);
  localparam int unsigned DISP_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_PAY = 2'd2,
    S_DISPENSE = 2'd3
  } state_t;

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [DISP_W-1:0]   r_disp_cnt;
  logic [IDX_W-1:0]    r_item;
  logic                r_sold_out;
  logic                r_timeout_err;
  logic                r_stray_done;
  logic [STOCK_W-1:0]  r_stock     [NUM_ITEMS];
  logic [STOCK_W-1:0]  w_stock_nxt [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] w_inc_hit;
  logic [NUM_ITEMS-1:0] w_dec_hit;
  logic                w_dec;
  logic [STOCK_W-1:0]  w_sel_stock;

  assign w_dec       = (r_state == S_WAIT_PAY) && pay_done;
  assign w_sel_stock = (32'(sel_item) < NUM_ITEMS) ? r_stock[sel_item] : '0;

  assign pay_req       = (r_state == S_REQ);
  assign dispense      = (r_state == S_DISPENSE);
  assign busy          = (r_state != S_IDLE);
  assign dispense_item = r_item;
  assign sold_out      = r_sold_out;
  assign timeout_err   = r_timeout_err;
  assign stray_done    = r_stray_done;
  assign stock_level   = w_sel_stock;

  // Restock and decrement of the same item cancel; restock saturates at max.
  always_comb begin
    w_inc_hit = '0;
    w_dec_hit = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      w_inc_hit[i]   = restock_valid && (restock_item == IDX_W'(i));
      w_dec_hit[i]   = w_dec && (r_item == IDX_W'(i));
      w_stock_nxt[i] = r_stock[i];
      if (w_inc_hit[i] && !w_dec_hit[i]) begin
        if (r_stock[i] != STOCK_MAX) w_stock_nxt[i] = r_stock[i] + STOCK_W'(1);
      end else if (w_dec_hit[i] && !w_inc_hit[i]) begin
        w_stock_nxt[i] = r_stock[i] - STOCK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= w_stock_nxt[i];
    end
  end

  // Transaction FSM with registered one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_disp_cnt    <= '0;
      r_item        <= '0;
      r_sold_out    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_stray_done  <= 1'b0;
    end else begin
      r_sold_out    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_stray_done  <= pay_done && (r_state != S_WAIT_PAY);
      unique case (r_state)
        S_IDLE: begin
          if (sel_valid) begin
            r_item <= sel_item;
            if (w_sel_stock != '0) r_state <= S_REQ;
            else                   r_sold_out <= 1'b1;
          end
        end
        S_REQ: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT_PAY;
        end
        S_WAIT_PAY: begin
          // Payment completion wins over an expiring timeout in the same cycle.
          if (pay_done) begin
            r_wait_cnt <= '0;
            r_disp_cnt <= '0;
            r_state    <= S_DISPENSE;
          end else if (r_wait_cnt == WAIT_W'(PAY_TIMEOUT - 1)) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        S_DISPENSE: begin
          if (r_disp_cnt == DISP_W'(DISPENSE_CYCLES - 1)) begin
            r_disp_cnt <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_disp_cnt <= r_disp_cnt + DISP_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: vend, sold-out, timeout, restock
// collisions, timeout boundary and reset during dispense.
module tb_vend_controller;

  logic       clk;
  logic       rst;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       restock_valid;
  logic [1:0] restock_item;
  logic       pay_req;
  logic       pay_done;
  logic       dispense;
  logic [1:0] dispense_item;
  logic       busy;
  logic       sold_out;
  logic       timeout_err;
  logic       stray_done;
  logic [3:0] stock_level;

  int checks;
  int errors;

  vend_controller #(
    .NUM_ITEMS(4), .STOCK_W(4), .INIT_STOCK(5), .PAY_TIMEOUT(16), .DISPENSE_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst),
    .sel_valid(sel_valid), .sel_item(sel_item),
    .restock_valid(restock_valid), .restock_item(restock_item),
    .pay_req(pay_req), .pay_done(pay_done),
    .dispense(dispense), .dispense_item(dispense_item),
    .busy(busy), .sold_out(sold_out), .timeout_err(timeout_err),
    .stray_done(stray_done), .stock_level(stock_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stock(input string tag, input int k, input int exp);
    sel_item = 2'(k);
    #1;
    chk(tag, 32'(stock_level), 32'(exp));
  endtask

  task automatic vend_fixed(input int k);
    sel_valid = 1'b1;
    sel_item  = 2'(k);
    tick();
    sel_valid = 1'b0;
    repeat (6) tick();
    pay_done = 1'b1;
    tick();
    pay_done = 1'b0;
    repeat (3) tick();
    chk("vend_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    sel_valid = 1'b0;
    sel_item = 2'd0;
    restock_valid = 1'b0;
    restock_item = 2'd0;
    pay_done = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pay_req", 32'(pay_req), 32'd0);
    chk("rst_dispense", 32'(dispense), 32'd0);
    chk("rst_item", 32'(dispense_item), 32'd0);
    chk("rst_pulses", {29'd0, sold_out, timeout_err, stray_done}, 32'd0);
    for (int k = 0; k < 4; k++) chk_stock("rst_stock", k, 5);
    rst = 1'b0;
    tick();

    // Normal vend of item 2, pay_done at T+6
    sel_valid = 1'b1;
    sel_item  = 2'd2;
    tick();
    sel_valid = 1'b0;
    chk("nv_req", 32'(pay_req), 32'd1);
    chk("nv_busy", 32'(busy), 32'd1);
    tick();
    chk("nv_req_once", 32'(pay_req), 32'd0);
    repeat (5) tick();
    chk("nv_no_early_disp", 32'(dispense), 32'd0);
    pay_done = 1'b1;
    tick();
    pay_done = 1'b0;
    chk("nv_disp1", 32'(dispense), 32'd1);
    chk("nv_disp_item", 32'(dispense_item), 32'd2);
    chk("nv_no_stray", 32'(stray_done), 32'd0);
    chk_stock("nv_stock2", 2, 4);
    tick();
    chk("nv_disp2", 32'(dispense), 32'd1);
    tick();
    chk("nv_disp3", 32'(dispense), 32'd1);
    tick();
    chk("nv_disp_end", 32'(dispense), 32'd0);
    chk("nv_busy_end", 32'(busy), 32'd0);

    // Sold out on item 1
    for (int n = 0; n < 5; n++) vend_fixed(1);
    chk_stock("so_stock1", 1, 0);
    sel_valid = 1'b1;
    sel_item  = 2'd1;
    tick();
    sel_valid = 1'b0;
    chk("so_pulse", 32'(sold_out), 32'd1);
    chk("so_no_req", 32'(pay_req), 32'd0);
    chk("so_idle", 32'(busy), 32'd0);
    tick();
    chk("so_pulse_end", 32'(sold_out), 32'd0);
    chk("so_no_req2", 32'(pay_req), 32'd0);
    chk("so_idle2", 32'(busy), 32'd0);
    chk_stock("so_stock1_after", 1, 0);

    // Payment timeout on item 0
    sel_valid = 1'b1;
    sel_item  = 2'd0;
    tick();
    sel_valid = 1'b0;
    tick();
    repeat (15) tick();
    chk("to_not_yet", 32'(timeout_err), 32'd0);
    chk("to_busy_last", 32'(busy), 32'd1);
    tick();
    chk("to_pulse", 32'(timeout_err), 32'd1);
    chk("to_no_disp", 32'(dispense), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    chk_stock("to_stock0", 0, 5);
    pay_done = 1'b1;
    tick();
    pay_done = 1'b0;
    chk("to_pulse_end", 32'(timeout_err), 32'd0);
    chk("stray_pulse", 32'(stray_done), 32'd1);
    chk("stray_idle", 32'(busy), 32'd0);
    tick();
    chk("stray_end", 32'(stray_done), 32'd0);

    // Restock colliding with decrement of item 3
    sel_valid = 1'b1;
    sel_item  = 2'd3;
    tick();
    sel_valid = 1'b0;
    repeat (6) tick();
    pay_done      = 1'b1;
    restock_valid = 1'b1;
    restock_item  = 2'd3;
    tick();
    pay_done      = 1'b0;
    restock_valid = 1'b0;
    chk("rc_disp", 32'(dispense), 32'd1);
    chk_stock("rc_stock3", 3, 5);
    repeat (3) tick();
    chk("rc_idle", 32'(busy), 32'd0);
    restock_valid = 1'b1;
    restock_item  = 2'd3;
    repeat (20) tick();
    restock_valid = 1'b0;
    chk_stock("sat_stock3", 3, 15);
    chk_stock("sat_stock2_indep", 2, 4);

    // pay_done exactly on the last wait cycle
    sel_valid = 1'b1;
    sel_item  = 2'd2;
    tick();
    sel_valid = 1'b0;
    tick();
    repeat (15) tick();
    chk("bd_still_wait", 32'(busy), 32'd1);
    chk("bd_no_to_yet", 32'(timeout_err), 32'd0);
    pay_done = 1'b1;
    tick();
    pay_done = 1'b0;
    chk("bd_disp", 32'(dispense), 32'd1);
    chk("bd_no_to", 32'(timeout_err), 32'd0);
    chk_stock("bd_stock2", 2, 3);
    tick();
    chk("bd_no_to2", 32'(timeout_err), 32'd0);
    repeat (2) tick();
    chk("bd_idle", 32'(busy), 32'd0);

    // Reset during dispense cycle 2
    sel_valid = 1'b1;
    sel_item  = 2'd0;
    tick();
    sel_valid = 1'b0;
    repeat (6) tick();
    pay_done = 1'b1;
    tick();
    pay_done = 1'b0;
    tick();
    chk("mr_disp_cyc2", 32'(dispense), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_disp", 32'(dispense), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_pulses", {29'd0, sold_out, timeout_err, stray_done}, 32'd0);
    chk("mr_item", 32'(dispense_item), 32'd0);
    for (int k = 0; k < 4; k++) chk_stock("mr_stock", k, 5);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_after_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Vending-machine transaction controller sitting directly upstream of the UPI payment engine.
- Accepts an item selection, checks per-item stock, issues a payment request and waits for payment completion with a timeout.
- On payment completion it drives the dispense actuator for a fixed number of cycles and decrements stock.
- Also handles restock events and reports sold-out and timeout errors.

Parameters:
- NUM_ITEMS, 4, number of selectable items; sel_item width is clog2(NUM_ITEMS).
- STOCK_W, 4, width of each per-item stock counter.
- INIT_STOCK, 5, stock value loaded into every item on reset; must be less than or equal to 2^STOCK_W-1.
- PAY_TIMEOUT, 16, maximum cycles spent in WAIT_PAY before aborting; must be at least 8.
- DISPENSE_CYCLES, 3, number of cycles dispense is held high.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- sel_valid  in  1  selection strobe, sampled only in IDLE
- sel_item  in  clog2(NUM_ITEMS)  selected item index
- restock_valid  in  1  adds one unit to restock_item, in any state
- restock_item  in  clog2(NUM_ITEMS)  item index to restock
- pay_req  out  1  payment request to the UPI engine
- pay_done  in  1  one-cycle payment-complete pulse from the UPI engine
- dispense  out  1  dispense actuator enable
- dispense_item  out  clog2(NUM_ITEMS)  item being dispensed (latched selection)
- busy  out  1  high in every state except IDLE
- sold_out  out  1  one-cycle pulse: selection rejected because stock is 0
- timeout_err  out  1  one-cycle pulse: payment timed out
- stray_done  out  1  one-cycle pulse: pay_done seen outside WAIT_PAY
- stock_level  out  STOCK_W  stock of sel_item, combinational read

Behaviour:
- Reset (async, on assertion):
  - State goes to IDLE.
  - All stock counters load INIT_STOCK.
  - Wait and dispense counters clear to 0.
  - Latched item clears to 0.
  - sold_out, timeout_err and stray_done clear to 0.
  - Reset mid-transaction abandons the transaction; there is no stock change and no pulse.
- Output decoding:
  - pay_req, dispense and busy are decoded from state.
  - dispense_item comes from the latched item register.
  - sold_out, timeout_err and stray_done are registered pulses, high for exactly one cycle.
- State machine: IDLE, REQ, WAIT_PAY, DISPENSE.
  - IDLE: on sel_valid, latch sel_item.
    - If its stock is greater than 0, go to REQ.
    - Otherwise pulse sold_out the next cycle and stay in IDLE.
    - sel_valid is ignored in every other state; no queuing.
  - REQ: pay_req is 1 for exactly this one cycle, then go to WAIT_PAY unconditionally.
  - WAIT_PAY:
    - The wait counter is 0 on entry and increments each cycle.
    - pay_done=1: go to DISPENSE and decrement stock of the latched item at that edge.
    - Otherwise, when the counter reaches PAY_TIMEOUT-1: go to IDLE, pulse timeout_err, no stock change.
    - pay_done takes priority over timeout in the same cycle.
  - DISPENSE: dispense is 1 for exactly DISPENSE_CYCLES cycles, counted by the dispense counter, then go to IDLE.
- Expected latency against the UPI engine:
  - pay_req asserted in cycle T.
  - pay_done arrives in cycle T+6.
  - dispense is high in cycles T+7 to T+6+DISPENSE_CYCLES.
  - Back in IDLE at T+7+DISPENSE_CYCLES.
- Stock arithmetic:
  - Restock saturates at 2^STOCK_W-1.
  - Decrement never underflows; it is only reachable with stock greater than 0.
  - Restock and decrement of the same item in the same cycle leave stock unchanged (net 0).
  - Different items update independently.
- stray_done: pay_done=1 in any state other than WAIT_PAY pulses stray_done the next cycle and is otherwise ignored.

Test Plan:
- Normal vend:
  - Stimulus: reset, sel_valid with sel_item=2; pay_done driven 6 cycles after pay_req.
  - Required: pay_req high for one cycle; dispense=1 with dispense_item=2 for 3 cycles; stock[2] goes 5 to 4; busy drops after dispense.
- Sold out:
  - Stimulus: vend item 1 five times, then select item 1 again.
  - Required: sold_out pulses once, pay_req stays 0, state remains IDLE, stock[1]=0.
- Timeout:
  - Stimulus: select item 0 and never assert pay_done.
  - Required: timeout_err pulses 16 cycles after WAIT_PAY entry; no dispense; stock[0] stays 5.
  - Follow-on: pay_done arriving afterwards gives a stray_done pulse.
- Simultaneous restock and decrement:
  - Stimulus: restock_valid with restock_item=3 in the same cycle pay_done completes an item-3 vend.
  - Required: stock[3] stays 5.
  - Saturation check: 20 restocks clamp at 15.
- Timeout boundary:
  - Stimulus: pay_done coincides with wait counter = PAY_TIMEOUT-1.
  - Required: DISPENSE is entered and timeout_err stays 0.
- Reset mid-operation:
  - Stimulus: assert rst during DISPENSE cycle 2.
  - Required: dispense, busy and all pulses go 0 immediately; every stock counter returns to 5.
